// File: rtl/freeze_writer.sv
// ---------------------------------------------------------------------------
// freeze_writer
//   Initiator side of the NCO freeze/sample interface. Takes a control word
//   from a ready/valid requester and presents it on `word`. It then fires a
//   one-cycle sample strobe `s` and holds the word for SETTLE cycles so the
//   update can propagate through the freeze stages. Finally it pulses `done`
//   and keeps a shadow copy of the committed word.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   requester has a new word (held until accepted)
//   req_data   in   requested word [WIDTH-1:0]
//   req_ready  out  block can accept a request (decoded: state == IDLE)
//   s          out  registered sample strobe to the freeze register
//   word       out  registered data bus to the freeze register input
//   busy       out  update in progress (decoded: state != IDLE)
//   done       out  registered one-cycle pulse: update committed
//   shadow     out  registered copy of the last committed word
// ---------------------------------------------------------------------------
module freeze_writer #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned SKIP_SAME = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  output logic             s,
  output logic [WIDTH-1:0] word,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow
);

  // Settle counter holds values 0..SETTLE; keep at least one bit.
  localparam int unsigned CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_s;
  logic             r_done;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_shadow;
  logic             w_accept;
  logic             w_same;

  // Handshake decode and redundant-request detection.
  always_comb begin
    w_accept = (r_state == ST_IDLE) && req_valid;
    w_same   = (SKIP_SAME != 0) && (req_data == r_shadow);
  end

  // Next-state and settle-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          // A word equal to the committed one needs no strobe.
          w_state_nxt = w_same ? ST_DONE : ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (SETTLE == 0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CNT_W'(SETTLE);
        end
      end
      ST_SETTLE: begin
        // Counter runs SETTLE..1; leaving on 1 spends exactly SETTLE cycles.
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_s      <= 1'b0;
      r_done   <= 1'b0;
      r_word   <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Strobe and done are registered from the next state so that each
      // is high for exactly the cycle spent in its state.
      r_s     <= (w_state_nxt == ST_STROBE);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_word <= req_data;
      end
      // Commit on DONE entry; a skipped request already matches the shadow.
      if ((w_state_nxt == ST_DONE) && (r_state != ST_IDLE)) begin
        r_shadow <= r_word;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign s         = r_s;
  assign done      = r_done;
  assign word      = r_word;
  assign shadow    = r_shadow;

endmodule

// File: tb/tb_freeze_writer.sv
// ---------------------------------------------------------------------------
// tb_freeze_writer
//   Two instances (SETTLE=2 and SETTLE=0). Stimulus computes each accepted
//   transaction's strobe/done edges from the latency rules and queues them.
//   A monitor compares the outputs every cycle against that queue.
// ---------------------------------------------------------------------------
module tb_freeze_writer;

  localparam int unsigned W = 12;

  typedef struct {
    logic [W-1:0] data;
    int           strobe_at;
    int           done_at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Count of rising edges so far; "cycle k" is between edge k and k+1.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input int g,
                              input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t edge=%0d actual=%0h required=%0h",
               name, g, $time, edge_cnt, act, req);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned ST = (g == 0) ? 2 : 0;

    logic         rst_n;
    logic         req_valid;
    logic [W-1:0] req_data;
    logic         req_ready;
    logic         s;
    logic [W-1:0] word;
    logic         busy;
    logic         done;
    logic [W-1:0] shadow;

    bit           chk_en    = 1'b0;
    bit           fin       = 1'b0;
    int           next_free = 0;
    logic [W-1:0] m_word    = '0;
    logic [W-1:0] m_shadow  = '0;
    logic [W-1:0] m_commit  = '0;
    exp_t         exp_q[$];

    freeze_writer #(.WIDTH(W), .SETTLE(ST), .SKIP_SAME(1)) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .s         (s),
      .word      (word),
      .busy      (busy),
      .done      (done),
      .shadow    (shadow)
    );

    // Drive one cycle of inputs and predict whether the next edge accepts.
    task automatic drive(input logic v, input logic [W-1:0] d, output bit acc);
      exp_t e;
      int   k;
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      acc       = 1'b0;
      if (v && (edge_cnt >= next_free)) begin
        k      = edge_cnt + 1;
        acc    = 1'b1;
        m_word = d;
        e.data = d;
        if (d == m_shadow) begin
          e.strobe_at = -1;
          e.done_at   = k;
          next_free   = k + 1;
        end else begin
          e.strobe_at = k;
          e.done_at   = k + 1 + int'(ST);
          next_free   = k + 2 + int'(ST);
        end
        m_shadow = d;
        exp_q.push_back(e);
      end
    endtask

    task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) drive(1'b0, req_data, a);
    endtask

    // Hold a request until the model says it is accepted (bounded).
    task automatic send(input logic [W-1:0] d);
      bit a;
      a = 1'b0;
      for (int i = 0; i < 40 && !a; i++) drive(1'b1, d, a);
      if (!a) chk("accept_timeout", g, 32'(a), 32'(1));
    endtask

    initial begin
      bit           a;
      bit           pend;
      logic [W-1:0] pd;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s",      g, 32'(s),         32'(0));
      chk("rst_word",   g, 32'(word),      32'(0));
      chk("rst_shadow", g, 32'(shadow),    32'(0));
      chk("rst_done",   g, 32'(done),      32'(0));
      chk("rst_busy",   g, 32'(busy),      32'(0));
      chk("rst_ready",  g, 32'(req_ready), 32'(1));
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Single update, skip-same, then a fresh word.
      send(12'hABC); idle(ST + 4);
      send(12'hABC); idle(3);
      send(12'h123); idle(ST + 4);

      // Request held while busy: second word taken as soon as ready returns.
      send(12'h001); send(12'h002); idle(ST + 4);

      // Randomised traffic obeying the hold-until-accepted rule.
      pend = 1'b0;
      pd   = '0;
      for (int i = 0; i < 300; i++) begin
        if (!pend && ($urandom_range(0, 1) == 1)) begin
          pend = 1'b1;
          pd   = ($urandom_range(0, 3) == 0) ? m_shadow : W'($urandom);
        end
        drive(pend, pend ? pd : req_data, a);
        if (a) pend = 1'b0;
      end
      idle(ST + 4);

      // Reset one cycle after the strobe.
      if (m_shadow == 12'hFFF) begin
        send(12'h000); idle(ST + 4);
      end
      send(12'hFFF);
      drive(1'b0, req_data, a);
      @(negedge clk);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("mid_rst_s",      g, 32'(s),         32'(0));
      chk("mid_rst_word",   g, 32'(word),      32'(0));
      chk("mid_rst_shadow", g, 32'(shadow),    32'(0));
      chk("mid_rst_done",   g, 32'(done),      32'(0));
      chk("mid_rst_busy",   g, 32'(busy),      32'(0));
      chk("mid_rst_ready",  g, 32'(req_ready), 32'(1));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("rst_hold_done", g, 32'(done), 32'(0));
        chk("rst_hold_s",    g, 32'(s),    32'(0));
      end
      rst_n     = 1'b1;
      m_word    = '0;
      m_shadow  = '0;
      next_free = 0;
      chk_en    = 1'b1;

      // Back-to-back requests under continuous valid.
      idle(2);
      send(12'h055); send(12'h056); send(12'h057);
      idle(ST + 5);
      fin = 1'b1;
    end

    // Monitor: compare every output against the queued expectations.
    always @(posedge clk) begin
      bit exp_s;
      bit exp_d;
      #1;
      if (!chk_en) begin
        m_commit = '0;
        exp_q.delete();
      end else begin
        exp_s = 1'b0;
        exp_d = 1'b0;
        if (exp_q.size() > 0) begin
          exp_s = (exp_q[0].strobe_at == edge_cnt);
          exp_d = (exp_q[0].done_at == edge_cnt);
        end
        chk("req_ready", g, 32'(req_ready), 32'(edge_cnt >= next_free));
        chk("busy",      g, 32'(busy),      32'(edge_cnt < next_free));
        chk("word",      g, 32'(word),      32'(m_word));
        chk("s",         g, 32'(s),         32'(exp_s));
        chk("done",      g, 32'(done),      32'(exp_d));
        if (exp_d) begin
          m_commit = exp_q[0].data;
          void'(exp_q.pop_front());
        end
        chk("shadow",    g, 32'(shadow),    32'(m_commit));
      end
    end
  end

  initial begin
    int i;
    i = 0;
    while (!(g_dut[0].fin && g_dut[1].fin) && i < 5000) begin
      @(posedge clk);
      i++;
    end
    if (!(g_dut[0].fin && g_dut[1].fin)) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout cycles=%0d required=finish", i);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
